// File: rtl/cbus_sram_ctrl_pkg.sv
// Shared CBus request/response types and burst-length encodings for the
// SRAM target.
package cbus_sram_ctrl_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  // len holds beats-1
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

endpackage

// File: rtl/cbus_sram_ctrl_sram_1rw.sv
// Single-port synchronous SRAM, 32-bit words, per-byte write enables and a
// registered read port with one cycle of latency. Contents are never reset.
module sram_1rw #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [3:0]              we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/cbus_sram_ctrl.sv
// CBus target serving single-beat and incrementing burst accesses to an
// on-chip SRAM at one beat per cycle, with one TURN cycle after each burst.
module cbus_sram_ctrl
  import cbus_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  req,
  output cbus_resp_t resp,
  output logic [1:0] dbg_state_o
);

  // Handshake: the master holds req stable with valid high until it observes
  // ready && last; every cycle with ready=1 is one consumed beat (no stalls),
  // and write data/strobe advance after each such beat.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_TURN  = 2'd3
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [3:0]            len_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic [ADDR_WIDTH-1:0] beat_idx;
  logic                  at_last;

  logic                  sram_en;
  logic [3:0]            sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_rdata;

  logic                  unused_req_bits;
  assign unused_req_bits = ^{req.size, req.addr[31:ADDR_WIDTH+2], req.addr[1:0]};

  assign req_idx     = req.addr[ADDR_WIDTH+1:2];
  assign beat_idx    = base_q + ADDR_WIDTH'(cnt_q);
  assign at_last     = (cnt_q == len_q);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      len_q   <= 4'd0;
      base_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req.valid) begin
            base_q  <= req_idx;
            len_q   <= req.len;
            cnt_q   <= 4'd0;
            state_q <= req.is_write ? S_WRITE : S_READ;
          end
        end
        S_READ, S_WRITE: begin
          if (at_last) state_q <= S_TURN;
          else         cnt_q   <= cnt_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reads are issued one beat ahead so the registered SRAM output lines up
  // with the beat that presents it.
  always_comb begin
    resp      = '0;
    sram_en   = 1'b0;
    sram_we   = 4'b0000;
    sram_addr = beat_idx;
    case (state_q)
      S_IDLE: begin
        if (req.valid && !req.is_write) begin
          sram_en   = 1'b1;
          sram_addr = req_idx;
        end
      end
      S_READ: begin
        resp.ready = 1'b1;
        resp.okay  = 1'b1;
        resp.last  = at_last;
        resp.data  = sram_rdata;
        if (!at_last) begin
          sram_en   = 1'b1;
          sram_addr = beat_idx + ADDR_WIDTH'(1);
        end
      end
      S_WRITE: begin
        resp.ready = 1'b1;
        resp.okay  = 1'b1;
        resp.last  = at_last;
        sram_en    = 1'b1;
        sram_we    = req.strobe;
      end
      default: ;
    endcase
  end

  sram_1rw #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (req.data),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_cbus_sram_ctrl.sv
// Directed bench for cbus_sram_ctrl: cycle-exact transactions with
// hand-computed expectations, one task per scenario.
module tb_cbus_sram_ctrl;
  import cbus_sram_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  cbus_req_t  req;
  cbus_resp_t resp;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_data   [0:15];
  logic        obs_ready [0:17];
  logic        obs_last  [0:17];
  logic        obs_okay  [0:17];
  logic [31:0] obs_data  [0:17];

  cbus_sram_ctrl #(.ADDR_WIDTH(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .resp        (resp),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one transaction starting just after a rising edge; cycle c=0 is the
  // acceptance cycle, beat k is cycle k+1, cycle len+2 is TURN.
  task automatic run_txn(input logic wr, input logic [31:0] addr,
                         input logic [3:0] len, input logic [3:0] strb);
    req          = '0;
    req.valid    = 1'b1;
    req.is_write = wr;
    req.size     = 2'd2;
    req.addr     = addr;
    req.strobe   = strb;
    req.len      = len;
    req.data     = wr ? wr_data[0] : 32'h0;
    for (int c = 0; c <= int'(len) + 2; c++) begin
      @(negedge clk);
      obs_ready[c] = resp.ready;
      obs_last[c]  = resp.last;
      obs_okay[c]  = resp.okay;
      obs_data[c]  = resp.data;
      @(posedge clk); #1;
      if (wr && c >= 1 && c <= int'(len)) req.data = wr_data[c];
      if (c == int'(len) + 1) req = '0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (resp !== '0) begin
      n_fail++; $display("FAIL reset_resp: got %h expected 0", resp);
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single_write_read;
    wr_data[0] = 32'hDEADBEEF;
    run_txn(1'b1, 32'h40, MLEN1, 4'hF);
    n_tests++;
    if ({obs_ready[0], obs_last[0], obs_okay[0]} !== 3'b000) begin
      n_fail++; $display("FAIL sw_accept_cycle: got r/l/o=%b%b%b expected 000",
                         obs_ready[0], obs_last[0], obs_okay[0]);
    end
    n_tests++;
    if ({obs_ready[1], obs_last[1], obs_okay[1]} !== 3'b111 || obs_data[1] !== 32'h0) begin
      n_fail++; $display("FAIL sw_beat: got r/l/o=%b%b%b data=%h expected 111 data=0",
                         obs_ready[1], obs_last[1], obs_okay[1], obs_data[1]);
    end
    n_tests++;
    if ({obs_ready[2], obs_last[2], obs_okay[2]} !== 3'b000 || obs_data[2] !== 32'h0) begin
      n_fail++; $display("FAIL sw_turn: got r/l/o=%b%b%b data=%h expected all 0",
                         obs_ready[2], obs_last[2], obs_okay[2], obs_data[2]);
    end
    run_txn(1'b0, 32'h40, MLEN1, 4'h0);
    n_tests++;
    if (obs_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL sr_accept_cycle: got ready=%b expected 0", obs_ready[0]);
    end
    n_tests++;
    if ({obs_ready[1], obs_last[1], obs_okay[1]} !== 3'b111 || obs_data[1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sr_beat: got r/l/o=%b%b%b data=%h expected 111 data=deadbeef",
                         obs_ready[1], obs_last[1], obs_okay[1], obs_data[1]);
    end
  endtask

  task automatic test_byte_strobe;
    wr_data[0] = 32'h000000AA;
    run_txn(1'b1, 32'h40, MLEN1, 4'h1);
    run_txn(1'b0, 32'h40, MLEN1, 4'h0);
    n_tests++;
    if (obs_data[1] !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL strobe_merge: got %h expected deadbeaa", obs_data[1]);
    end
    run_txn(1'b0, 32'h4040, MLEN1, 4'h0);
    n_tests++;
    if (obs_data[1] !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL addr_alias: got %h expected deadbeaa", obs_data[1]);
    end
  endtask

  task automatic test_burst16;
    for (int k = 0; k < 16; k++) wr_data[k] = 32'(k);
    run_txn(1'b1, 32'h100, MLEN16, 4'hF);
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (obs_ready[k+1] !== 1'b1 || obs_last[k+1] !== (k == 15)) begin
        n_fail++; $display("FAIL wburst_beat%0d: got ready=%b last=%b expected ready=1 last=%b",
                           k, obs_ready[k+1], obs_last[k+1], (k == 15));
      end
    end
    run_txn(1'b0, 32'h100, MLEN16, 4'h0);
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({obs_ready[k+1], obs_okay[k+1]} !== 2'b11 || obs_last[k+1] !== (k == 15) ||
          obs_data[k+1] !== 32'(k)) begin
        n_fail++; $display("FAIL rburst_beat%0d: got r/o=%b%b last=%b data=%h expected 11 last=%b data=%h",
                           k, obs_ready[k+1], obs_okay[k+1], obs_last[k+1], obs_data[k+1],
                           (k == 15), 32'(k));
      end
    end
    n_tests++;
    if ({obs_ready[17], obs_last[17], obs_okay[17]} !== 3'b000 || obs_data[17] !== 32'h0 ||
        dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rburst_turn: got r/l/o=%b%b%b data=%h state_after=%0d expected 000 0 0",
                         obs_ready[17], obs_last[17], obs_okay[17], obs_data[17], dbg_state);
    end
  endtask

  task automatic test_wrap;
    for (int k = 0; k < 4; k++) wr_data[k] = 32'hA0 + 32'(k);
    run_txn(1'b1, 32'h3FF8, MLEN4, 4'hF);
    run_txn(1'b0, 32'h0000, MLEN1, 4'h0);
    n_tests++;
    if (obs_data[1] !== 32'hA2) begin
      n_fail++; $display("FAIL wrap_word0: got %h expected a2", obs_data[1]);
    end
    run_txn(1'b0, 32'h0004, MLEN1, 4'h0);
    n_tests++;
    if (obs_data[1] !== 32'hA3) begin
      n_fail++; $display("FAIL wrap_word1: got %h expected a3", obs_data[1]);
    end
    run_txn(1'b0, 32'h3FF8, MLEN2, 4'h0);
    n_tests++;
    if (obs_data[1] !== 32'hA0 || obs_data[2] !== 32'hA1 || obs_last[2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap_top_words: got %h %h last=%b expected a0 a1 last=1",
                         obs_data[1], obs_data[2], obs_last[2]);
    end
  endtask

  task automatic test_reset_mid_burst;
    req          = '0;
    req.valid    = 1'b1;
    req.addr     = 32'h100;
    req.len      = MLEN8;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (resp.ready !== 1'b1 || resp.data !== 32'h3) begin
      n_fail++; $display("FAIL mid_burst_beat3: got ready=%b data=%h expected 1 00000003",
                         resp.ready, resp.data);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (resp !== '0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_burst_reset: got resp=%h state=%0d expected 0 0", resp, dbg_state);
    end
    @(posedge clk); #1;
    req   = '0;
    reset = 1'b0;
    run_txn(1'b0, 32'h104, MLEN1, 4'h0);
    n_tests++;
    if ({obs_ready[1], obs_last[1]} !== 2'b11 || obs_data[1] !== 32'h1) begin
      n_fail++; $display("FAIL post_reset_read: got r/l=%b%b data=%h expected 11 00000001",
                         obs_ready[1], obs_last[1], obs_data[1]);
    end
  endtask

  task automatic test_back_to_back;
    req          = '0;
    req.valid    = 1'b1;
    req.is_write = 1'b1;
    req.addr     = 32'h200;
    req.strobe   = 4'hF;
    req.data     = 32'h12345678;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({resp.ready, resp.last} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_first_last: got r/l=%b%b expected 11", resp.ready, resp.last);
    end
    @(posedge clk); #1;
    req          = '0;
    req.valid    = 1'b1;
    req.addr     = 32'h200;
    @(negedge clk);
    n_tests++;
    if (resp.ready !== 1'b0 || dbg_state !== 2'd3) begin
      n_fail++; $display("FAIL b2b_turn_ignores: got ready=%b state=%0d expected 0 3", resp.ready, dbg_state);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (resp.ready !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL b2b_accept_cycle: got ready=%b state=%0d expected 0 0", resp.ready, dbg_state);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({resp.ready, resp.last} !== 2'b11 || resp.data !== 32'h12345678) begin
      n_fail++; $display("FAIL b2b_second_beat: got r/l=%b%b data=%h expected 11 12345678",
                         resp.ready, resp.last, resp.data);
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    n_tests++;
    if (resp !== '0) begin
      n_fail++; $display("FAIL b2b_second_turn: got %h expected 0", resp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_byte_strobe();
    test_burst16();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
